// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_seq
// Purpose  : Iterative RV32M multiply/divide sequencer. Accepts one op through
//            a valid/ready handshake, iterates one bit per cycle (shift-add
//            multiply, restoring divide), applies the sign fix-up and holds
//            the 32-bit result on mul_din until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] mul_din,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]  C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  C_ONES    = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(XLEN - 1);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  // a_q: multiplicand (shifted left) or dividend/quotient shift register
  logic [2*XLEN-1:0]   a_q, a_d;
  // b_q: multiplier magnitude (shifted right) or divisor magnitude
  logic [XLEN-1:0]     b_q, b_d;
  // acc_q: product accumulator or partial remainder in the low XLEN+1 bits
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     mul_din_q, mul_din_d;
  logic                resp_valid_q, resp_valid_d;

  // Request decode: which operands are signed, their magnitudes, result sign
  logic            w_is_div, w_is_rem, w_sa, w_sb, w_neg, w_div0, w_ovf;
  logic [XLEN-1:0] w_ma, w_mb;

  assign w_is_div = req_op[2];
  assign w_is_rem = req_op[2] & req_op[1];
  assign w_sa     = w_is_div ? (~req_op[0] & req_a[XLEN-1])
                             : ((req_op == 3'd1 || req_op == 3'd2) & req_a[XLEN-1]);
  assign w_sb     = w_is_div ? (~req_op[0] & req_b[XLEN-1])
                             : ((req_op == 3'd1) & req_b[XLEN-1]);
  assign w_ma     = w_sa ? (~req_a + 1'b1) : req_a;
  assign w_mb     = w_sb ? (~req_b + 1'b1) : req_b;
  assign w_neg    = w_is_rem ? w_sa : (w_sa ^ w_sb);
  assign w_div0   = w_is_div & (req_b == '0);
  assign w_ovf    = w_is_div & ~req_op[0] & (req_a == C_INT_MIN) & (req_b == C_ONES);

  // Iteration datapath: one multiply step and one restoring-divide step
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN:0]     w_trial, w_diff;
  logic              w_qbit;

  assign w_mul_acc = acc_q + (b_q[0] ? a_q : '0);
  assign w_trial   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, b_q};
  assign w_qbit    = ~w_diff[XLEN];

  // Fix-up: negate the full 64-bit product before slicing the high half
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dmag, w_dres, w_result;

  assign w_prod   = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign w_dmag   = op_q[1] ? acc_q[XLEN-1:0] : a_q[XLEN-1:0];
  assign w_dres   = neg_q ? (~w_dmag + 1'b1) : w_dmag;
  assign w_result = op_q[2]          ? w_dres :
                    (op_q == 3'd0)   ? w_prod[XLEN-1:0] :
                                       w_prod[2*XLEN-1:XLEN];

  // State register and datapath flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
      mul_din_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      cnt_q        <= cnt_d;
      mul_din_q    <= mul_din_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state and datapath update; flush overrides every state
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    cnt_d        = cnt_q;
    mul_din_d    = mul_din_q;
    resp_valid_d = resp_valid_q;

    if (flush) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d  = req_op;
            a_d   = {{XLEN{1'b0}}, w_ma};
            b_d   = w_mb;
            acc_d = '0;
            neg_d = w_neg;
            cnt_d = '0;
            if (w_div0) begin
              mul_din_d    = w_is_rem ? req_a : C_ONES;
              resp_valid_d = 1'b1;
              state_d      = S_DONE;
            end else if (w_ovf) begin
              mul_din_d    = w_is_rem ? '0 : C_INT_MIN;
              resp_valid_d = 1'b1;
              state_d      = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            acc_d = {{(XLEN-1){1'b0}}, (w_qbit ? w_diff : w_trial)};
            a_d   = {a_q[2*XLEN-1:XLEN], a_q[XLEN-2:0], w_qbit};
          end else begin
            acc_d = w_mul_acc;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end
          if (cnt_q == C_LAST) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          mul_din_d    = w_result;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign mul_din    = mul_din_q;

endmodule
`default_nettype wire

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Iterative multiply/divide sequencer for the RISCV 32M operations.
- Sits beside the single-cycle ALU. The core issues M-extension ops here through a valid/ready handshake.
- The finished 32-bit result is driven onto the ALU's mul_din operand path with a response handshake.
- The core stalls on req_ready/resp_valid; the ALU itself is never stalled by this block.

Parameters:
- XLEN, 32, operand and result width (only 32 is supported).
- CNT_W, 6, width of the iteration counter (must hold XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous reset, active low.
- req_valid  input  1  operation request valid.
- req_ready  output  1  block can accept a request (IDLE only).
- req_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a  input  32  rs1 operand.
- req_b  input  32  rs2 operand.
- flush  input  1  synchronous abort of any in-flight op.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts the result.
- mul_din  output  32  result, routed to ALU mul_din.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, mul_din=0, resp_valid=0, busy=0, counter=0, all internal registers 0. req_ready=1 once reset is released.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch op and operands.
  - Operand conversion at latch time:
    - Signed operands (MULH both; MULHSU rs1 only; DIV/REM both) are converted to magnitude.
    - Record the result-sign flag: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Special cases, which go directly to DONE with the result loaded (latency 1):
    - Divide by zero (req_b==0): DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> req_a.
    - Signed overflow (DIV/REM with req_a==32'h80000000 and req_b==32'hFFFFFFFF): DIV -> 32'h80000000; REM -> 0.
  - All other cases go to CALC with counter=0.
- CALC: one bit per cycle for exactly 32 cycles; counter increments each edge; leaves to FIX when counter==31 at the edge.
  - Multiply: shift-add on a 64-bit accumulator, LSB-first from the rs2 magnitude.
  - Divide: restoring division, MSB-first; 33-bit partial remainder; quotient bit = no-borrow.
- FIX: one cycle.
  - Apply two's-complement negation when the sign flag is set.
  - Select result: MUL -> low 32 bits; MULH* -> high 32 bits; DIV* -> quotient; REM* -> remainder.
  - Register the result into mul_din; go to DONE.
- Normal latency: request accepted at edge E0, resp_valid high after edge E33 (34 cycles).
- DONE:
  - resp_valid=1; mul_din held stable until handshake.
  - On an edge with resp_ready=1: resp_valid falls and the state returns to IDLE.
  - No new request is accepted in the same cycle: req_ready=0 throughout DONE.
- mul_din keeps the last result after the handshake; it is only rewritten at the next FIX or special-case load.
- flush=1:
  - In CALC, FIX or DONE: next state IDLE, resp_valid=0, result discarded, mul_din unchanged.
  - In IDLE: flush has priority over req_valid, so no request is accepted that cycle.
- Asynchronous reset mid-operation aborts immediately to reset values; no response is produced.
- req_op, req_a and req_b are ignored outside IDLE; the latched copies are used throughout the op.
- busy = (state != IDLE).

Test Plan:
- MUL a=7, b=6 -> resp_valid exactly 34 cycles after accept, mul_din=42. MULHU a=b=32'hFFFFFFFF -> mul_din=32'hFFFFFFFE.
- MULH a=32'hFFFFFFFF (-1), b=2 -> 32'hFFFFFFFF. MULHSU a=-1, b=32'hFFFFFFFF -> 32'hFFFFFFFF. MUL a=-3, b=5 -> 32'hFFFFFFF1.
- DIV a=-7, b=2 -> 32'hFFFFFFFD (-3). REM a=-7, b=2 -> 32'hFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2.
- Boundary results, each with 1-cycle latency:
  - DIVU a=5, b=0 -> 32'hFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000.
  - REM of the same operands -> 0.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid -> resp_valid and mul_din stable, req_ready=0. Raise resp_ready -> IDLE next edge, req_ready=1.
- Aborts:
  - flush at CALC cycle 15 -> IDLE next edge, no resp_valid, mul_din unchanged.
  - rstn low during CALC -> immediate reset values.
  - A new DIVU 9/3 afterwards -> 3.
